// File: rtl/box_draw.sv
// Filled-box rasteriser: one BOX_W x BOX_H box per accepted request, one pixel per clock,
// with pixels off the SCREEN_W x SCREEN_H screen skipped instead of wrapped.
module box_draw #(
   parameter int BOX_W    = 4,
   parameter int BOX_H    = 4,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_x,
   input  logic [6:0] req_y,
   input  logic [2:0] req_colour,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

   localparam logic [3:0] OX_LAST = 4'(BOX_W - 1);
   localparam logic [3:0] OY_LAST = 4'(BOX_H - 1);
   localparam logic [8:0] SCR_W   = 9'(SCREEN_W);
   localparam logic [7:0] SCR_H   = 8'(SCREEN_H);

   state_t     state_q, state_d;
   logic [7:0] x0_q, x0_d;
   logic [6:0] y0_q, y0_d;
   logic [2:0] col_q, col_d;
   logic [3:0] ox_q, ox_d, oy_q, oy_d;
   logic [7:0] vx_q, vx_d;
   logic [6:0] vy_q, vy_d;
   logic [2:0] vc_q, vc_d;
   logic       plot_q, plot_d;

   // Pixel to be presented next cycle: base origin plus offsets
   logic       emit;
   logic [7:0] px_base;
   logic [6:0] py_base;
   logic [2:0] p_col;
   logic [3:0] p_ox, p_oy;
   logic [8:0] x_sum;
   logic [7:0] y_sum;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         col_q   <= '0;
         ox_q    <= '0;
         oy_q    <= '0;
         vx_q    <= '0;
         vy_q    <= '0;
         vc_q    <= '0;
         plot_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         col_q   <= col_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         vx_q    <= vx_d;
         vy_q    <= vy_d;
         vc_q    <= vc_d;
         plot_q  <= plot_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      col_d   = col_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      vx_d    = vx_q;
      vy_d    = vy_q;
      vc_d    = vc_q;
      plot_d  = 1'b0;
      emit    = 1'b0;
      px_base = x0_q;
      py_base = y0_q;
      p_col   = col_q;
      p_ox    = '0;
      p_oy    = '0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               // Pixel 0 comes straight from the request so it is on the outputs next cycle
               state_d = S_DRAW;
               x0_d    = req_x;
               y0_d    = req_y;
               col_d   = req_colour;
               ox_d    = '0;
               oy_d    = '0;
               emit    = 1'b1;
               px_base = req_x;
               py_base = req_y;
               p_col   = req_colour;
            end
         end
         S_DRAW: begin
            if (ox_q == OX_LAST && oy_q == OY_LAST) begin
               state_d = S_DONE;
            end else begin
               if (ox_q == OX_LAST) begin
                  ox_d = '0;
                  oy_d = oy_q + 4'd1;
               end else begin
                  ox_d = ox_q + 4'd1;
               end
               emit = 1'b1;
               p_ox = ox_d;
               p_oy = oy_d;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      x_sum = {1'b0, px_base} + {5'b0, p_ox};
      y_sum = {1'b0, py_base} + {4'b0, p_oy};
      if (emit) begin
         vx_d   = x_sum[7:0];
         vy_d   = y_sum[6:0];
         vc_d   = p_col;
         plot_d = (x_sum < SCR_W) && (y_sum < SCR_H);
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign vga_x      = vx_q;
   assign vga_y      = vy_q;
   assign vga_colour = vc_q;
   assign vga_plot   = plot_q;

endmodule

// File: tb/tb_box_draw.sv
// Directed bench for box_draw: table of 4x4 boxes plus hand-written sequences, and a 5x3 build.
module tb_box_draw;

   logic       clk = 1'b0;
   logic       resetn;
   logic       rv, rv2;
   logic [7:0] rx, rx2;
   logic [6:0] ry, ry2;
   logic [2:0] rc, rc2;
   logic       rdy, rdy2, plot, plot2, busy, busy2, done, done2;
   logic [7:0] vx, vx2;
   logic [6:0] vy, vy2;
   logic [2:0] vc, vc2;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   box_draw dut (
      .clk(clk), .resetn(resetn), .req_valid(rv), .req_ready(rdy),
      .req_x(rx), .req_y(ry), .req_colour(rc),
      .vga_x(vx), .vga_y(vy), .vga_colour(vc), .vga_plot(plot),
      .busy(busy), .done(done)
   );

   box_draw #(.BOX_W(5), .BOX_H(3)) dut53 (
      .clk(clk), .resetn(resetn), .req_valid(rv2), .req_ready(rdy2),
      .req_x(rx2), .req_y(ry2), .req_colour(rc2),
      .vga_x(vx2), .vga_y(vy2), .vga_colour(vc2), .vga_plot(plot2),
      .busy(busy2), .done(done2)
   );

   typedef struct {
      logic [7:0]  x;
      logic [6:0]  y;
      logic [2:0]  c;
      logic [15:0] mask;   // expected vga_plot per pixel k
   } vec_t;

   vec_t tbl[5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      else
         passed++;
   endtask

   // {ready,busy,done,plot,x,y,colour}
   function automatic logic [31:0] st1();
      return {8'd0, rdy, busy, done, plot, vx, vy, vc};
   endfunction

   task automatic run_box(input vec_t v, input string tag);
      chk({tag, " ready"}, {31'd0, rdy}, 32'd1);
      rv = 1'b1; rx = v.x; ry = v.y; rc = v.c;
      tick();
      rv = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("%s px%0d", tag, k), {8'd0, busy, plot, vx, vy, vc, 4'd0},
             {8'd0, 1'b1, v.mask[k], 8'(v.x + k % 4), 7'(v.y + k / 4), v.c, 4'd0});
         tick();
      end
      chk({tag, " done"}, st1(),
          {8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'(v.x + 3), 7'(v.y + 3), v.c});
      tick();
      chk({tag, " idle"}, {28'd0, rdy, busy, done, plot}, 32'b1000);
   endtask

   initial begin
      tbl[0] = '{8'd43,  7'd7,   3'd7, 16'hFFFF};
      tbl[1] = '{8'd158, 7'd118, 3'd3, 16'h0033};
      tbl[2] = '{8'd157, 7'd0,   3'd1, 16'h7777};
      tbl[3] = '{8'd0,   7'd117, 3'd4, 16'h0FFF};
      tbl[4] = '{8'd255, 7'd126, 3'd6, 16'h0000};

      resetn = 1'b0;
      rv = 1'b0; rx = '0; ry = '0; rc = '0;
      rv2 = 1'b0; rx2 = '0; ry2 = '0; rc2 = '0;
      #2;
      chk("reset state", st1(), {8'd0, 4'b1000, 18'd0});
      tick(); tick();
      resetn = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) begin
         run_box(tbl[i], $sformatf("box%0d", i));
         tick();
      end

      // Held request with new data during DRAW/DONE: ignored until ready returns
      rv = 1'b1; rx = 8'd43; ry = 7'd7; rc = 3'd7;
      tick();
      rx = 8'd10; ry = 7'd20; rc = 3'd2;
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("hold px%0d", k), {13'd0, plot, vx, vy, vc},
             {13'd0, 1'b1, 8'(43 + k % 4), 7'(7 + k / 4), 3'd7});
         tick();
      end
      chk("hold done17", {28'd0, rdy, busy, done, plot}, 32'b0110);
      tick();
      chk("hold ready18", {28'd0, rdy, busy, done, plot}, 32'b1000);
      tick();
      rv = 1'b0;
      chk("second box px0", st1(), {8'd0, 4'b0101, 8'd10, 7'd20, 3'd2});
      for (int k = 0; k < 17; k++) tick();
      chk("second box idle", {31'd0, rdy}, 32'd1);

      // Reset in DRAW cycle 5
      rv = 1'b1; rx = 8'd43; ry = 7'd7; rc = 3'd7;
      tick();
      rv = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("pre-reset px4", {13'd0, plot, vx, vy, vc}, {13'd0, 1'b1, 8'd43, 7'd8, 3'd7});
      resetn = 1'b0;
      #1;
      chk("mid reset state", st1(), {8'd0, 4'b1000, 18'd0});
      tick();
      resetn = 1'b1;
      for (int k = 0; k < 20; k++) begin
         total++;
         if (done !== 1'b0) begin
            $display("FAIL no done after reset: got %b, expected 0", done);
            break;
         end
         passed++;
         tick();
      end
      run_box(tbl[0], "post-reset");
      tick();

      // 5x3 build
      chk("5x3 ready", {31'd0, rdy2}, 32'd1);
      rv2 = 1'b1; rx2 = 8'd118; ry2 = 7'd46; rc2 = 3'd5;
      tick();
      rv2 = 1'b0;
      for (int k = 0; k < 15; k++) begin
         chk($sformatf("5x3 px%0d", k), {12'd0, busy2, plot2, vx2, vy2, vc2},
             {12'd0, 1'b1, 1'b1, 8'(118 + k % 5), 7'(46 + k / 5), 3'd5});
         tick();
      end
      chk("5x3 done16", {12'd0, done2, plot2, vx2, vy2, vc2},
          {12'd0, 1'b1, 1'b0, 8'd122, 7'd48, 3'd5});
      tick();
      chk("5x3 idle17", {29'd0, rdy2, busy2, done2}, 32'b100);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
